// File: rtl/pg2_cla_if.sv
// Signal bundle for the two-bit lookahead unit: per-bit p/g and carry-in
// toward the unit, combinational and registered lookahead terms back.
interface pg2_cla_if;
    logic       cin;
    logic [1:0] p;
    logic [1:0] g;
    logic [2:1] c;
    logic       gg;
    logic       pg;
    logic [2:1] c_q;
    logic       gg_q;
    logic       pg_q;

    // No valid/ready: inputs are sampled every cycle and outputs are always valid.
    modport master (
        output cin, p, g,
        input  c, gg, pg, c_q, gg_q, pg_q
    );

    modport slave (
        input  cin, p, g,
        output c, gg, pg, c_q, gg_q, pg_q
    );
endinterface

// File: rtl/pg2_cla.sv
// Two-bit carry-lookahead cell: flat AND-OR carries and group p/g terms,
// plus a free-running register stage for pipelined adder builds.
module pg2_cla (
    input  logic     clk,
    input  logic     rst,
    pg2_cla_if.slave bus
);
    logic [2:1] c;
    logic       gg;
    logic       pg;

    // Carries are flattened to two gate levels rather than rippled.
    assign c[1] = bus.g[0] | (bus.p[0] & bus.cin);
    assign c[2] = bus.g[1] | (bus.p[1] & bus.g[0]) | (bus.p[1] & bus.p[0] & bus.cin);
    assign gg   = bus.g[1] | (bus.p[1] & bus.g[0]);
    assign pg   = bus.p[1] & bus.p[0];

    assign bus.c  = c;
    assign bus.gg = gg;
    assign bus.pg = pg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.c_q  <= 2'b00;
            bus.gg_q <= 1'b0;
            bus.pg_q <= 1'b0;
        end else begin
            bus.c_q  <= c;
            bus.gg_q <= gg;
            bus.pg_q <= pg;
        end
    end
endmodule

// File: tb/tb_pg2_cla.sv
// Self-checking bench for pg2_cla: exhaustive combinational sweep, directed
// cases, randomized pipeline run against a bit-serial carry model, async reset.
module tb_pg2_cla;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [3:0] exp_q[$];

    pg2_cla_if bus ();

    pg2_cla dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the carry bit by bit (generate sets, propagate passes, else kill).
    function automatic logic [2:1] ref_carry(input logic ci, input logic [1:0] pp, input logic [1:0] gv);
        logic [2:1] r;
        logic       carry;
        carry = ci;
        for (int i = 0; i < 2; i++) begin
            if (gv[i])      carry = 1'b1;
            else if (!pp[i]) carry = 1'b0;
            r[i+1] = carry;
        end
        return r;
    endfunction

    // {c[2:1], gg, pg}: gg is carry-out with no carry-in, pg is carry-out of a lone carry-in.
    function automatic logic [3:0] ref_all(input logic ci, input logic [1:0] pp, input logic [1:0] gv);
        logic [2:1] cc;
        logic [2:1] cg;
        logic [2:1] cp;
        cc = ref_carry(ci, pp, gv);
        cg = ref_carry(1'b0, pp, gv);
        cp = ref_carry(1'b1, pp, 2'b00);
        return {cc, cg[2], cp[2]};
    endfunction

    task automatic drive(input logic ci, input logic [1:0] pp, input logic [1:0] gv);
        bus.cin = ci;
        bus.p   = pp;
        bus.g   = gv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'b11, 2'b11);
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.c_q, bus.gg_q, bus.pg_q} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_hold: got %b expected 0000", {bus.c_q, bus.gg_q, bus.pg_q});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [4:0] v;
        logic [3:0] exp;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            drive(v[4], v[3:2], v[1:0]);
            #1;
            exp = ref_all(v[4], v[3:2], v[1:0]);
            n_checks++;
            if ({bus.c, bus.gg, bus.pg} !== exp) begin
                n_errors++;
                $display("FAIL sweep in=%b: got %b expected %b", v, {bus.c, bus.gg, bus.pg}, exp);
            end
            #1;
        end
    endtask

    task automatic test_directed();
        logic [3:0] exp [6];
        logic [4:0] stim [6];
        stim[0] = 5'b1_11_00; exp[0] = 4'b11_0_1;  // full propagate
        stim[1] = 5'b0_10_01; exp[1] = 4'b11_1_0;  // generate dominance
        stim[2] = 5'b1_00_00; exp[2] = 4'b00_0_0;  // kill
        stim[3] = 5'b1_00_10; exp[3] = 4'b10_1_0;  // kill then g[1]
        stim[4] = 5'b1_01_00; exp[4] = 4'b01_0_0;  // partial propagate
        stim[5] = 5'b0_11_11; exp[5] = 4'b11_1_1;  // p and g both high
        for (int i = 0; i < 6; i++) begin
            drive(stim[i][4], stim[i][3:2], stim[i][1:0]);
            #1;
            n_checks++;
            if ({bus.c, bus.gg, bus.pg} !== exp[i]) begin
                n_errors++;
                $display("FAIL directed%0d in=%b: got %b expected %b", i, stim[i], {bus.c, bus.gg, bus.pg}, exp[i]);
            end
        end
    endtask

    task automatic test_pipeline_latency();
        @(negedge clk);
        drive(1'b1, 2'b11, 2'b00);
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.c_q, bus.pg_q} !== 3'b111) begin
            n_errors++;
            $display("FAIL latency_edge_n: got c_q=%b pg_q=%b expected c_q=11 pg_q=1", bus.c_q, bus.pg_q);
        end
        drive(1'b0, 2'b11, 2'b00);
        #1;
        n_checks++;
        if (bus.c_q !== 2'b11) begin
            n_errors++;
            $display("FAIL latency_hold: got c_q=%b expected 11 before next edge", bus.c_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.c_q !== 2'b00) begin
            n_errors++;
            $display("FAIL latency_edge_n1: got c_q=%b expected 00", bus.c_q);
        end
    endtask

    task automatic test_random_pipeline();
        logic       ci;
        logic [1:0] pp;
        logic [1:0] gv;
        logic [3:0] exp;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ci = 1'($urandom_range(0, 1));
            pp = 2'($urandom_range(0, 3));
            gv = 2'($urandom_range(0, 3));
            drive(ci, pp, gv);
            exp_q.push_back(ref_all(ci, pp, gv));
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({bus.c_q, bus.gg_q, bus.pg_q} !== exp) begin
                n_errors++;
                $display("FAIL random_pipe%0d in=%b%b%b: got %b expected %b", i, ci, pp, gv,
                         {bus.c_q, bus.gg_q, bus.pg_q}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 2'b11, 2'b00);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.c_q !== 2'b11) begin
            n_errors++;
            $display("FAIL areset_pre: got c_q=%b expected 11", bus.c_q);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.c_q, bus.gg_q, bus.pg_q} !== 4'b0000) begin
            n_errors++;
            $display("FAIL areset_clear: got %b expected 0000", {bus.c_q, bus.gg_q, bus.pg_q});
        end
        n_checks++;
        if (bus.c !== 2'b11) begin
            n_errors++;
            $display("FAIL areset_comb: got c=%b expected 11", bus.c);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.c_q, bus.gg_q, bus.pg_q} !== 4'b0000) begin
            n_errors++;
            $display("FAIL areset_hold: got %b expected 0000", {bus.c_q, bus.gg_q, bus.pg_q});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.c_q !== 2'b00) begin
            n_errors++;
            $display("FAIL areset_release_wait: got c_q=%b expected 00 before edge", bus.c_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.c_q, bus.gg_q, bus.pg_q} !== 4'b1101) begin
            n_errors++;
            $display("FAIL areset_release: got %b expected 1101", {bus.c_q, bus.gg_q, bus.pg_q});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_comb_sweep();
        test_directed();
        test_pipeline_latency();
        test_random_pipeline();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
